// File: rtl/match_pkg.sv
// Shared types and sizing for the phase match core and its row cache.
package match_pkg;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_IDLE   = 2'd1,
    S_SEARCH = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam int ROW_SIZE_DEF   = 1280;
  localparam int WIN_SIZE_DEF   = 128;
  localparam int BEAT_SIZE_DEF  = 8;
  localparam int DATA_WIDTH_DEF = 16;

  localparam int BEATS_PER_ROW = ROW_SIZE_DEF / BEAT_SIZE_DEF;
  localparam int COST_W        = DATA_WIDTH_DEF + 1;

  function automatic int beats_per_row(input int row_size, input int beat_size);
    return row_size / beat_size;
  endfunction

  // One extra bit so |a - b| of two signed samples never overflows.
  function automatic int cost_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/match_cache.sv
// One-row phase2 cache split into even/odd beat banks so any unaligned
// BEAT_SIZE-lane window is read in a single cycle (1-cycle latency).
module match_cache
  import match_pkg::*;
#(
  parameter int ROW_SIZE   = ROW_SIZE_DEF,
  parameter int BEAT_SIZE  = BEAT_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int LW = BEAT_SIZE * DATA_WIDTH,
  localparam int AW = $clog2(ROW_SIZE),
  localparam int OW = $clog2(BEAT_SIZE),
  localparam int BW = AW - OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_beat,
  input  logic [LW-1:0] wr_data,
  input  logic [AW-1:0] rd_start,
  output logic [LW-1:0] rd_data
);

  localparam int HALF = beats_per_row(ROW_SIZE, BEAT_SIZE) / 2;
  localparam int HW   = BW - 1;

  logic [LW-1:0]   even_mem [HALF];
  logic [LW-1:0]   odd_mem  [HALF];
  logic [BW-1:0]   beat_s;
  logic [HW-1:0]   even_addr_s;
  logic [HW-1:0]   odd_addr_s;
  logic [LW-1:0]   q_even_r;
  logic [LW-1:0]   q_odd_r;
  logic            odd_sel_r;
  logic [OW-1:0]   off_r;
  logic [LW-1:0]   lo_s;
  logic [LW-1:0]   hi_s;
  logic [2*LW-1:0] win_s;

  // Bank addresses for the window's first beat and its successor (wraps at row end).
  always_comb begin
    beat_s     = rd_start[AW-1:OW];
    odd_addr_s = beat_s[BW-1:1];
    if (beat_s[0]) begin
      if (beat_s[BW-1:1] == HW'(HALF - 1)) begin
        even_addr_s = '0;
      end else begin
        even_addr_s = beat_s[BW-1:1] + HW'(1);
      end
    end else begin
      even_addr_s = beat_s[BW-1:1];
    end
  end

  // Row storage; intentionally not reset, the next load overwrites it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_beat[0]) begin
        odd_mem[wr_beat[BW-1:1]] <= wr_data;
      end else begin
        even_mem[wr_beat[BW-1:1]] <= wr_data;
      end
    end
  end

  // Registered bank reads plus the window alignment they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_even_r  <= '0;
      q_odd_r   <= '0;
      odd_sel_r <= 1'b0;
      off_r     <= '0;
    end else begin
      q_even_r  <= even_mem[even_addr_s];
      q_odd_r   <= odd_mem[odd_addr_s];
      odd_sel_r <= beat_s[0];
      off_r     <= rd_start[OW-1:0];
    end
  end

  // Order the two beats and slice out the unaligned window.
  always_comb begin
    if (odd_sel_r) begin
      lo_s = q_odd_r;
      hi_s = q_even_r;
    end else begin
      lo_s = q_even_r;
      hi_s = q_odd_r;
    end
    win_s   = {hi_s, lo_s};
    rd_data = win_s[int'(off_r) * DATA_WIDTH +: LW];
  end

endmodule

// File: rtl/match_core.sv
// Phase matcher: loads a phase2 row, then per request scans WIN_SIZE offsets
// on every lane and reports the offset of the smallest absolute difference.
module match_core
  import match_pkg::*;
#(
  parameter int ROW_SIZE   = ROW_SIZE_DEF,
  parameter int WIN_SIZE   = WIN_SIZE_DEF,
  parameter int BEAT_SIZE  = BEAT_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s_cache_axis_tdata,
  input  logic                         s_cache_axis_tvalid,
  output logic                         s_cache_axis_tready,
  input  logic                         s_cache_axis_tlast,
  input  logic signed [DATA_WIDTH-1:0] abs_phase1     [BEAT_SIZE],
  input  logic signed [DATA_WIDTH-1:0] abs_phase1_pos [BEAT_SIZE],
  input  logic                         vld_i,
  output logic signed [DATA_WIDTH-1:0] disparity      [BEAT_SIZE],
  output logic [BEAT_SIZE-1:0]         vld_o
);

  localparam int BEATS = beats_per_row(ROW_SIZE, BEAT_SIZE);
  localparam int CW    = cost_width(DATA_WIDTH);
  localparam int AW    = $clog2(ROW_SIZE);
  localparam int BW    = AW - $clog2(BEAT_SIZE);
  localparam int DCW   = $clog2(WIN_SIZE + 2);
  localparam int RCW   = $clog2(BEATS + 1);
  localparam int XW    = DATA_WIDTH + 2;

  state_t                       state_r, state_next_s;
  logic [DCW-1:0]               d_r;
  logic [BW-1:0]                waddr_r;
  logic [RCW-1:0]               req_cnt_r;
  logic signed [DATA_WIDTH-1:0] p1_r  [BEAT_SIZE];
  logic signed [DATA_WIDTH-1:0] pos_r [BEAT_SIZE];
  logic                         accept_s, capture_s, last_off_s, row_done_s;
  logic signed [XW-1:0]         d_ext_s, x0_s;
  logic signed [XW-1:0]         x_s [BEAT_SIZE];
  logic [AW-1:0]                start_s;
  logic [BEAT_SIZE-1:0]         ok_s, s1_ok_r, s2_ok_r;
  logic                         s1_vld_r, s2_vld_r;
  logic [DCW-1:0]               s1_d_r, s2_d_r;
  logic [BEAT_SIZE*DATA_WIDTH-1:0] rd_data_s;
  logic signed [DATA_WIDTH-1:0] lane_s [BEAT_SIZE];
  logic signed [CW-1:0]         diff_s [BEAT_SIZE];
  logic [CW-1:0]                cost_s [BEAT_SIZE];
  logic [CW-1:0]                cost_r [BEAT_SIZE];
  logic [CW-1:0]                best_cost_r [BEAT_SIZE];
  logic [CW-1:0]                best_cost_next_s [BEAT_SIZE];
  logic [DCW-1:0]               best_d_r [BEAT_SIZE];
  logic [DCW-1:0]               best_d_next_s [BEAT_SIZE];

  assign accept_s   = s_cache_axis_tvalid && s_cache_axis_tready;
  assign capture_s  = (state_r == S_IDLE) && vld_i;
  assign last_off_s = (d_r == DCW'(WIN_SIZE + 1));
  assign row_done_s = ((req_cnt_r + RCW'(1)) == RCW'(BEATS));

  match_cache #(
    .ROW_SIZE  (ROW_SIZE),
    .BEAT_SIZE (BEAT_SIZE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cache (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_s),
    .wr_beat (waddr_r),
    .wr_data (s_cache_axis_tdata),
    .rd_start(start_s),
    .rd_data (rd_data_s)
  );

  // State register plus offset counter, write pointer and request count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_LOAD;
      d_r       <= '0;
      waddr_r   <= '0;
      req_cnt_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == S_SEARCH && !last_off_s) d_r <= d_r + DCW'(1);
      else d_r <= '0;
      if (accept_s) begin
        if (s_cache_axis_tlast || waddr_r == BW'(BEATS - 1)) waddr_r <= '0;
        else waddr_r <= waddr_r + BW'(1);
      end
      if (accept_s && s_cache_axis_tlast) req_cnt_r <= '0;
      else if (state_r == S_RESULT) req_cnt_r <= req_cnt_r + RCW'(1);
    end
  end

  // Next-state logic; the SEARCH tail covers the read and compare pipeline drain.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_LOAD:   if (accept_s && s_cache_axis_tlast) state_next_s = S_IDLE; else state_next_s = S_LOAD;
      S_IDLE:   if (capture_s) state_next_s = S_SEARCH; else state_next_s = S_IDLE;
      S_SEARCH: if (last_off_s) state_next_s = S_RESULT; else state_next_s = S_SEARCH;
      S_RESULT: if (row_done_s) state_next_s = S_LOAD; else state_next_s = S_IDLE;
      default:  state_next_s = S_LOAD;
    endcase
  end

  // Window start and per-lane candidate validity for the current offset.
  always_comb begin
    d_ext_s = XW'(d_r);
    x0_s    = XW'(pos_r[0]) - d_ext_s;
    if (x0_s[XW-1]) start_s = AW'(x0_s + XW'(ROW_SIZE));
    else if (x0_s >= XW'(ROW_SIZE)) start_s = '0;
    else start_s = AW'(x0_s);
    for (int i = 0; i < BEAT_SIZE; i++) begin
      x_s[i]  = XW'(pos_r[i]) - d_ext_s;
      ok_s[i] = !x_s[i][XW-1] && (x_s[i] < XW'(ROW_SIZE));
    end
  end

  // Absolute difference cost and strict-less argmin update per lane.
  always_comb begin
    for (int i = 0; i < BEAT_SIZE; i++) begin
      lane_s[i] = rd_data_s[i*DATA_WIDTH +: DATA_WIDTH];
      diff_s[i] = CW'(p1_r[i]) - CW'(lane_s[i]);
      cost_s[i] = diff_s[i][CW-1] ? CW'(-diff_s[i]) : CW'(diff_s[i]);
      if (s2_vld_r && s2_ok_r[i] && (cost_r[i] < best_cost_r[i])) begin
        best_cost_next_s[i] = cost_r[i];
        best_d_next_s[i]    = s2_d_r;
      end else begin
        best_cost_next_s[i] = best_cost_r[i];
        best_d_next_s[i]    = best_d_r[i];
      end
    end
  end

  // Request capture, read/compare pipeline tags and running best per lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_r <= 1'b0;
      s2_vld_r <= 1'b0;
      s1_d_r   <= '0;
      s2_d_r   <= '0;
      s1_ok_r  <= '0;
      s2_ok_r  <= '0;
      for (int i = 0; i < BEAT_SIZE; i++) begin
        p1_r[i]        <= '0;
        pos_r[i]       <= '0;
        cost_r[i]      <= '0;
        best_cost_r[i] <= '1;
        best_d_r[i]    <= '0;
      end
    end else begin
      s1_vld_r <= (state_r == S_SEARCH) && (d_r < DCW'(WIN_SIZE));
      s1_d_r   <= d_r;
      s1_ok_r  <= ok_s;
      s2_vld_r <= s1_vld_r;
      s2_d_r   <= s1_d_r;
      s2_ok_r  <= s1_ok_r;
      for (int i = 0; i < BEAT_SIZE; i++) begin
        cost_r[i] <= cost_s[i];
        if (capture_s) begin
          p1_r[i]        <= abs_phase1[i];
          pos_r[i]       <= abs_phase1_pos[i];
          best_cost_r[i] <= '1;
          best_d_r[i]    <= '0;
        end else begin
          best_cost_r[i] <= best_cost_next_s[i];
          best_d_r[i]    <= best_d_next_s[i];
        end
      end
    end
  end

  // Registered outputs: tready, result strobe and held disparity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cache_axis_tready <= 1'b1;
      vld_o               <= '0;
      for (int i = 0; i < BEAT_SIZE; i++) disparity[i] <= '0;
    end else begin
      s_cache_axis_tready <= (state_next_s == S_LOAD);
      if (state_next_s == S_RESULT) begin
        vld_o <= '1;
        for (int i = 0; i < BEAT_SIZE; i++) disparity[i] <= DATA_WIDTH'(best_d_next_s[i]);
      end else begin
        vld_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_match_core.sv
// Self-checking bench for match_core: table-driven requests on a ramp row,
// tie/reset corner sequences, and randomized rows against a reference model.
module tb_match_core;

  localparam int ROW   = 64;
  localparam int WIN   = 8;
  localparam int BEAT  = 8;
  localparam int DW    = 16;
  localparam int BEATS = ROW / BEAT;

  typedef struct {
    int base;
    int shift;
    int exp;
    bit poke;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [BEAT*DW-1:0]   tdata;
  logic                 tvalid, tready, tlast;
  logic signed [DW-1:0] p1   [BEAT];
  logic signed [DW-1:0] pos  [BEAT];
  logic                 vld_i;
  logic signed [DW-1:0] disp [BEAT];
  logic [BEAT-1:0]      vld_o;

  int n_pass  = 0;
  int n_total = 0;
  int pulses  = 0;
  int p2 [ROW];

  always #5 clk = ~clk;

  match_core #(.ROW_SIZE(ROW), .WIN_SIZE(WIN), .BEAT_SIZE(BEAT), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .s_cache_axis_tdata (tdata),
    .s_cache_axis_tvalid(tvalid),
    .s_cache_axis_tready(tready),
    .s_cache_axis_tlast (tlast),
    .abs_phase1         (p1),
    .abs_phase1_pos     (pos),
    .vld_i              (vld_i),
    .disparity          (disp),
    .vld_o              (vld_o)
  );

  always @(posedge clk) if (vld_o != '0) pulses <= pulses + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: best offset per lane straight from the matching rule.
  function automatic int ref_disp(input int base, input int lane, input int v);
    int best;
    int bd;
    best = 1 << 30;
    bd   = 0;
    for (int d = 0; d < WIN; d++) begin
      int x;
      int c;
      x = base + lane - d;
      if (x >= 0 && x < ROW) begin
        c = v - p2[x];
        if (c < 0) c = -c;
        if (c < best) begin
          best = c;
          bd   = d;
        end
      end
    end
    return bd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(output int hs);
    int b;
    bit acc;
    b  = 0;
    hs = 0;
    for (int it = 0; it < 400 && b < BEATS; it++) begin
      for (int i = 0; i < BEAT; i++) tdata[i*DW +: DW] = p2[b*BEAT + i][DW-1:0];
      tlast  = (b == BEATS - 1);
      tvalid = ($urandom_range(0, 2) != 0);
      acc    = tvalid && tready;
      tick();
      if (acc) begin
        b++;
        hs++;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic request(input int base, input int vals [BEAT], input bit poke,
                         input int tab_exp, input string name);
    int lat;
    bit seen;
    int exp_d [BEAT];
    for (int i = 0; i < BEAT; i++) begin
      pos[i]   = DW'(base + i);
      p1[i]    = DW'(vals[i]);
      exp_d[i] = ref_disp(base, i, vals[i]);
    end
    vld_i = 1'b1;
    tick();
    vld_i = 1'b0;
    lat   = 1;
    seen  = 1'b0;
    while (!seen && lat < 60) begin
      if (vld_o != '0) begin
        seen = 1'b1;
      end else begin
        vld_i = poke && (lat == 3);
        tick();
        lat++;
      end
    end
    vld_i = 1'b0;
    check($sformatf("%s_latency", name), lat, WIN + 3);
    check($sformatf("%s_vld_o", name), vld_o, 8'hFF);
    for (int i = 0; i < BEAT; i++) begin
      check($sformatf("%s_disp%0d", name, i), disp[i], exp_d[i]);
      if (tab_exp >= 0) check($sformatf("%s_tab%0d", name, i), disp[i], tab_exp);
    end
    tick();
    check($sformatf("%s_vld_o_drop", name), vld_o, 0);
    check($sformatf("%s_hold", name), disp[BEAT-1], exp_d[BEAT-1]);
  endtask

  initial begin
    vec_t tab [8];
    int   vals [BEAT];
    int   hs;
    int   p0;
    int   rdy;
    int   nz;

    tab = '{'{16, 3, 3, 1'b0}, '{0, 0, 0, 1'b0}, '{24, 7, 7, 1'b1}, '{40, 5, 5, 1'b0},
            '{8, 1, 1, 1'b0},  '{56, 0, 0, 1'b0}, '{32, 2, 2, 1'b0}, '{48, 6, 6, 1'b0}};
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    vld_i  = 1'b0;
    for (int i = 0; i < BEAT; i++) begin
      p1[i]  = '0;
      pos[i] = '0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_tready", tready, 1);
    check("reset_vld_o", vld_o, 0);
    nz = 0;
    for (int i = 0; i < BEAT; i++) if (disp[i] != 0) nz++;
    check("reset_disp_nonzero_lanes", nz, 0);

    // Ramp row loaded with a stuttering tvalid.
    for (int x = 0; x < ROW; x++) p2[x] = 4 * x;
    load_row(hs);
    check("load_beats", hs, BEATS);
    check("idle_tready", tready, 0);

    // Beats offered outside LOAD must not be taken.
    tvalid = 1'b1;
    tdata  = '1;
    rdy    = 0;
    for (int k = 0; k < 3; k++) begin
      if (tready) rdy++;
      tick();
    end
    tvalid = 1'b0;
    check("idle_no_accept", rdy, 0);

    p0 = pulses;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < BEAT; i++) vals[i] = 4 * (tab[r].base + i - tab[r].shift);
      request(tab[r].base, vals, tab[r].poke, tab[r].exp, $sformatf("tab%0d", r));
    end
    check("row_pulse_count", pulses - p0, 8);
    check("row_done_tready", tready, 1);

    // Flat row: every offset ties, smallest offset must win.
    for (int x = 0; x < ROW; x++) p2[x] = 100;
    load_row(hs);
    check("flat_load_beats", hs, BEATS);
    for (int i = 0; i < BEAT; i++) vals[i] = 100;
    request(16, vals, 1'b0, 0, "tie");

    // Reset while the search is at offset 4.
    for (int i = 0; i < BEAT; i++) begin
      pos[i] = DW'(20 + i);
      p1[i]  = DW'(100);
    end
    vld_i = 1'b1;
    tick();
    vld_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    p0 = pulses;
    repeat (WIN + 6) tick();
    check("rst_no_vld_o", pulses - p0, 0);
    check("rst_tready", tready, 1);
    nz = 0;
    for (int i = 0; i < BEAT; i++) if (disp[i] != 0) nz++;
    check("rst_disp_nonzero_lanes", nz, 0);

    // Randomized rows against the reference model.
    for (int row = 0; row < 2; row++) begin
      for (int x = 0; x < ROW; x++) p2[x] = int'($urandom_range(0, 60000)) - 30000;
      load_row(hs);
      check($sformatf("rand%0d_load_beats", row), hs, BEATS);
      for (int r = 0; r < BEATS; r++) begin
        int base;
        int sh;
        base = int'($urandom_range(0, ROW - BEAT));
        sh   = int'($urandom_range(0, WIN - 1));
        for (int i = 0; i < BEAT; i++) begin
          int x;
          x = base + i - sh;
          if (x < 0 || $urandom_range(0, 3) == 0) vals[i] = int'($urandom_range(0, 60000)) - 30000;
          else vals[i] = p2[x] + int'($urandom_range(0, 6)) - 3;
        end
        request(base, vals, 1'b0, -1, $sformatf("rand%0d_%0d", row, r));
      end
      check($sformatf("rand%0d_reload_tready", row), tready, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/match_core.md
MATCH_CORE -- requirements
Module: match_core

Interface
REQ-001 Parameter ROW_SIZE, default 1280: phase samples per row.
REQ-002 Parameter WIN_SIZE, default 128: search offsets per request, d = 0..WIN_SIZE-1.
REQ-003 Parameter BEAT_SIZE, default 8: lanes per beat; ROW_SIZE is a multiple of BEAT_SIZE.
REQ-004 Parameter DATA_WIDTH, default 16: signed sample width.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 s_cache_axis_tdata  in  BEAT_SIZE*DATA_WIDTH  phase2 beat; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_cache_axis_tvalid/tready/tlast  in/out/in  1 each  AXIS handshake; tlast marks the final phase2 beat of the row.
REQ-009 abs_phase1  in  BEAT_SIZE x DATA_WIDTH signed  phase1 samples of one request.
REQ-010 abs_phase1_pos  in  BEAT_SIZE x DATA_WIDTH signed  column of each lane, pos[i] = base + i.
REQ-011 vld_i  in  1  single-cycle request strobe.
REQ-012 disparity  out  BEAT_SIZE x DATA_WIDTH signed  per-lane result.
REQ-013 vld_o  out  BEAT_SIZE  per-lane result-valid strobe.

Function
REQ-014 The FSM SHALL have states S_LOAD, S_IDLE, S_SEARCH and S_RESULT; S_LOAD is entered at reset.
REQ-015 In S_LOAD: tready = 1; each accepted beat is written to cache beat address waddr, and waddr increments modulo ROW_SIZE/BEAT_SIZE.
REQ-016 Accepting the beat with tlast: go to S_IDLE, clear waddr and clear req_cnt; tready = 0 in every other state.
REQ-017 S_IDLE with vld_i: capture phase1 and pos[0] as base, then go to S_SEARCH; vld_i in any other state is dropped, with no state change.
REQ-018 S_SEARCH: one offset d per cycle, d = 0..WIN_SIZE-1; every lane reads candidate x = pos[i] - d in the same cycle.
REQ-019 Cache reads: the cache is banked even/odd beat; reading two adjacent beats gives any BEAT_SIZE-element unaligned window in one cycle; read latency 1 cycle.
REQ-020 Cost per lane: |phase1[i] - phase2[x]| at DATA_WIDTH+1 bits, no overflow; candidates with x < 0 are skipped.
REQ-021 Best match per lane: strictly smaller cost replaces best, so a tie keeps the smaller d; disparity[i] = best d.
REQ-022 After the last offset drains the read and compare pipeline, go to S_RESULT.
REQ-023 S_RESULT lasts one cycle: vld_o = all ones, disparity is held stable, req_cnt increments.
REQ-024 Exit from S_RESULT: go to S_LOAD if req_cnt reaches ROW_SIZE/BEAT_SIZE, otherwise go to S_IDLE.
REQ-025 Latency: vld_i high in cycle t, with S_IDLE, gives vld_o high in cycle t+WIN_SIZE+3 exactly.
REQ-026 vld_o is 0 outside S_RESULT; disparity holds its last value until the next result.
REQ-027 phase2 beats presented while not in S_LOAD are not accepted (tready = 0) and are not lost.

Reset
REQ-028 Asserting rst, including mid-load or mid-search, SHALL force S_LOAD, waddr = 0, req_cnt = 0, vld_o = 0, disparity = 0 and tready = 1 after release.
REQ-029 Cache contents SHALL NOT be reset; the next row load overwrites them.
REQ-030 A request in flight at reset SHALL produce no vld_o.

Structure
REQ-031 A shared package match_pkg SHALL hold the state enum and the localparams BEATS_PER_ROW = ROW_SIZE/BEAT_SIZE and the cost width.
REQ-032 The even/odd banked cache with its unaligned window extraction SHALL be one sub-module, match_cache.
REQ-033 The FSM, the offset counter and the per-lane compare/argmin SHALL remain in match_core.

Verification
REQ-034 Setup for all scenarios: ROW_SIZE=64, WIN_SIZE=8, BEAT_SIZE=8.
REQ-035 Scenario 1: load phase2[x] = 4x; request base=16, phase1[i] = 4*(16+i-3) -> disparity = 3 on all lanes, vld_o = 0xFF at t+11.
REQ-036 Scenario 2: request base=0, phase1 = phase2 at the same column -> disparity = 0; candidates with x < 0 are ignored and produce no X values.
REQ-037 Scenario 3: tie, phase2 constant 100 with phase1 = 100 -> disparity = 0 (smallest d wins).
REQ-038 Scenario 4: 8 requests complete a row -> FSM returns to S_LOAD and tready rises; a vld_i sent during S_SEARCH is ignored, so exactly 8 vld_o pulses occur.
REQ-039 Scenario 5: toggle tvalid during load; tlast on beat 8 -> exactly 8 beats are written and the FSM goes to S_IDLE.
REQ-040 Scenario 6: assert rst at offset d=4 of a search -> no vld_o, S_LOAD, tready = 1 after release.
